// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_fetch_pkg
// Shared types and default sizes for the instruction fetch slice.
//   fetch_state_t : fetch FSM states (S_REQ, S_WAIT, S_HOLD, S_DRAIN)
//   ADDR_W_DEF    : default PC / instruction-memory address width
//   INSTR_W_DEF   : default instruction width
//   RESET_PC_DEF  : default PC loaded on reset
// -----------------------------------------------------------------------------
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam int ADDR_W_DEF   = 8;
  localparam int INSTR_W_DEF  = 16;
  localparam int RESET_PC_DEF = 0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imem_req   : read request (fetch -> memory)
//   imem_addr  : read address (fetch -> memory)
//   imem_rdata : read data, valid with imem_valid (memory -> fetch)
//   imem_valid : one-cycle response pulse (memory -> fetch)
// Modports: master = fetch unit, slave = memory.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/instr_fetch_unit_perf_counter.sv
// -----------------------------------------------------------------------------
// fetch_perf_counter
// 16-bit event counter that saturates at 16'hFFFF.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (count -> 0)
//   inc   : count one event this cycle
//   count : current count
// -----------------------------------------------------------------------------
module fetch_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  // Stop counting once all ones so the value never wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'h0000;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC, issues single-outstanding reads to instruction
// memory, holds each returned word in the IR for the decoder and discards
// wrong-path responses after a redirect.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   imem         : instruction-memory bus (master side)
//   ir, ir_pc    : instruction register and the address it came from
//   ir_valid     : ir holds an undelivered instruction
//   ir_ready     : downstream accepts ir this cycle
//   redirect     : load redirect_pc as the new PC (highest priority)
//   fetch_cnt    : delivered instructions (FETCH_PERF_CNT_EN only)
//   flush_cnt    : redirect cycles (FETCH_PERF_CNT_EN only)
// Build option: define FETCH_PERF_CNT_EN to add the saturating counters.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  ir,
  output logic [ADDR_W-1:0]   ir_pc,
  output logic                ir_valid,
  input  logic                ir_ready,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         fetch_cnt,
  output logic [15:0]         flush_cnt
`endif
);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] ir_nxt;
  logic [ADDR_W-1:0]  ir_pc_nxt;
  logic               ir_valid_nxt;

  // The request is gated by rst_n so nothing is issued while reset is held.
  assign imem.imem_req  = rst_n && (state == S_REQ);
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_valid <= ir_valid_nxt;
    end
  end

  // A redirect overrides any response or handshake in the same cycle. If a
  // request is still in flight, the FSM drains it; a response arriving in the
  // redirect cycle itself is that drained response.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = ir_valid;

    if (redirect) begin
      pc_nxt       = redirect_pc;
      ir_valid_nxt = 1'b0;
      case (state)
        S_REQ:   state_nxt = S_DRAIN;
        S_WAIT:  state_nxt = imem.imem_valid ? S_REQ : S_DRAIN;
        S_HOLD:  state_nxt = S_REQ;
        S_DRAIN: state_nxt = imem.imem_valid ? S_REQ : S_DRAIN;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_valid) begin
            ir_nxt       = imem.imem_rdata;
            ir_pc_nxt    = pc;
            ir_valid_nxt = 1'b1;
            pc_nxt       = pc + ADDR_W'(1);
            state_nxt    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            ir_valid_nxt = 1'b0;
            state_nxt    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem.imem_valid) begin
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc;

  // A handshake in a redirect cycle is cancelled, so it is not a delivery.
  assign fetch_inc = ir_valid && ir_ready && !redirect;

  fetch_perf_counter u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fetch_inc),
    .count (fetch_cnt)
  );

  fetch_perf_counter u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit: a default instance (RESET_PC=0) with a
// latency-programmable memory model, and a second instance with RESET_PC=FF
// for the PC wrap case. Perf-counter scenarios run when FETCH_PERF_CNT_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
  import cpu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ir, ir2;
  logic [7:0]  ir_pc, ir_pc2;
  logic        ir_valid, ir_valid2;
  logic        ir_ready = 1'b0;
  logic        ir_ready2 = 1'b1;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  int          lat = 1;

  instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();
  instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus2 ();

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt2, flush_cnt2;
`endif

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFF)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus2),
    .ir          (ir2),
    .ir_pc       (ir_pc2),
    .ir_valid    (ir_valid2),
    .ir_ready    (ir_ready2),
    .redirect    (1'b0),
    .redirect_pc (8'h00)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt2),
    .flush_cnt   (flush_cnt2)
`endif
  );

  always #5 clk = ~clk;

  // Memory model for the main instance: answers each request after 'lat'
  // cycles (lat=1 means the response is presented the cycle after the
  // request); an in-flight request is forgotten on reset.
  logic       pend;
  int         cnt;
  logic [7:0] paddr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend            <= 1'b0;
      cnt             <= 0;
      paddr           <= 8'h00;
      bus.imem_valid  <= 1'b0;
      bus.imem_rdata  <= 16'h0000;
    end else begin
      bus.imem_valid <= 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= mem[paddr];
          pend           <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.imem_req) begin
        paddr <= bus.imem_addr;
        if (lat <= 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= mem[bus.imem_addr];
        end else begin
          pend <= 1'b1;
          cnt  <= lat - 2;
        end
      end
    end
  end

  // Memory model for the wrap instance: fixed one-cycle latency, data C0:addr.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus2.imem_valid <= 1'b0;
      bus2.imem_rdata <= 16'h0000;
    end else begin
      bus2.imem_valid <= bus2.imem_req;
      bus2.imem_rdata <= {8'hC0, bus2.imem_addr};
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Hold reset for two cycles, then release; on return the current cycle is
  // the first one out of reset (state S_REQ).
  task automatic reset_dut();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    ir_ready    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ir_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s: ir_valid timeout, got 0 want 1", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    #1;
    checks += 6;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b want 0", bus.imem_req); end
    if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_ir_valid: got %b want 0", ir_valid); end
    if (ir !== 16'h0000) begin errors++; $display("[TB] FAIL rst_ir: got %h want 0000", ir); end
    if (ir_pc !== 8'h00) begin errors++; $display("[TB] FAIL rst_ir_pc: got %h want 00", ir_pc); end
    if (bus.imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL rst_pc: got %h want 00", bus.imem_addr); end
    if (bus2.imem_addr !== 8'hFF) begin errors++; $display("[TB] FAIL rst_pc2: got %h want ff", bus2.imem_addr); end

    // Reset in the middle of a wait abandons the request.
    lat = 3;
    reset_dut();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req: got %b want 0", bus.imem_req); end
    tick();
    rst_n = 1'b1;
    #1;
    checks += 2;
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL midrst_rereq: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL midrst_addr: got %h want 00", bus.imem_addr); end
  endtask

  task automatic test_fetch_seq();
    logic [7:0]  addrs[$];
    logic [15:0] irs[$];
    logic [7:0]  irpcs[$];
    int          run = 0;
    int          maxrun = 0;
    mem[0] = 16'h0020;
    lat    = 1;
    reset_dut();
    ir_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (bus.imem_req) addrs.push_back(bus.imem_addr);
      if (ir_valid) begin
        run++;
        if (run == 1) begin
          irs.push_back(ir);
          irpcs.push_back(ir_pc);
        end
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      tick();
    end
    checks += 2;
    if (addrs.size() != 3) begin errors++; $display("[TB] FAIL seq_nreq: got %0d want 3", addrs.size()); end
    if (irs.size() != 3) begin errors++; $display("[TB] FAIL seq_ndeliv: got %0d want 3", irs.size()); end
    if (addrs.size() == 3 && irs.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (addrs[k] !== 8'(k)) begin errors++; $display("[TB] FAIL seq_addr%0d: got %h want %h", k, addrs[k], 8'(k)); end
        if (irpcs[k] !== 8'(k)) begin errors++; $display("[TB] FAIL seq_irpc%0d: got %h want %h", k, irpcs[k], 8'(k)); end
        if (irs[k] !== ((k == 0) ? 16'h0020 : {8'(k), 8'(k)})) begin
          errors++; $display("[TB] FAIL seq_ir%0d: got %h", k, irs[k]);
        end
      end
    end
    checks++;
    if (maxrun != 1) begin errors++; $display("[TB] FAIL seq_valid_len: got %0d want 1", maxrun); end
  endtask

  task automatic test_hold_stall();
    lat = 1;
    reset_dut();
    wait_valid("stall_wait");
    for (int c = 0; c < 5; c++) begin
      tick();
      checks += 4;
      if (ir !== 16'h0020) begin errors++; $display("[TB] FAIL stall_ir: got %h want 0020", ir); end
      if (ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid: got %b want 1", ir_valid); end
      if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b want 0", bus.imem_req); end
      if (bus.imem_addr !== 8'h01) begin errors++; $display("[TB] FAIL stall_pc: got %h want 01", bus.imem_addr); end
    end
    ir_ready = 1'b1;
    tick();
    checks += 3;
    if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_valid: got %b want 0", ir_valid); end
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 8'h01) begin errors++; $display("[TB] FAIL stall_release_addr: got %h want 01", bus.imem_addr); end
  endtask

  task automatic test_redirect_hold();
    lat = 1;
    reset_dut();
    wait_valid("rhold_wait");
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    ir_ready    = 1'b1;
    tick();
    redirect = 1'b0;
    checks += 4;
    if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL rhold_valid: got %b want 0", ir_valid); end
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rhold_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 8'h40) begin errors++; $display("[TB] FAIL rhold_addr: got %h want 40", bus.imem_addr); end
    if (ir !== 16'h0020) begin errors++; $display("[TB] FAIL rhold_ir_kept: got %h want 0020", ir); end
    wait_valid("rhold_deliver");
    checks += 2;
    if (ir_pc !== 8'h40) begin errors++; $display("[TB] FAIL rhold_irpc: got %h want 40", ir_pc); end
    if (ir !== 16'h4040) begin errors++; $display("[TB] FAIL rhold_ir: got %h want 4040", ir); end
  endtask

  task automatic test_redirect_wait();
    mem[0]   = 16'h1111;
    lat      = 3;
    reset_dut();
    ir_ready = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    checks += 2;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rwait_drain_req: got %b want 0", bus.imem_req); end
    if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL rwait_drain_valid: got %b want 0", ir_valid); end
    tick();
    tick();
    checks += 3;
    if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL rwait_discard: got %b want 0", ir_valid); end
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rwait_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 8'h10) begin errors++; $display("[TB] FAIL rwait_addr: got %h want 10", bus.imem_addr); end
    wait_valid("rwait_deliver");
    checks += 2;
    if (ir !== 16'h1010) begin errors++; $display("[TB] FAIL rwait_ir: got %h want 1010", ir); end
    if (ir_pc !== 8'h10) begin errors++; $display("[TB] FAIL rwait_irpc: got %h want 10", ir_pc); end
  endtask

  task automatic test_redirect_same_cycle();
    lat      = 2;
    reset_dut();
    ir_ready = 1'b1;
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 8'h30;
    tick();
    redirect = 1'b0;
    checks += 3;
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rsame_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 8'h30) begin errors++; $display("[TB] FAIL rsame_addr: got %h want 30", bus.imem_addr); end
    if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsame_valid: got %b want 0", ir_valid); end
    wait_valid("rsame_deliver");
    checks++;
    if (ir_pc !== 8'h30) begin errors++; $display("[TB] FAIL rsame_irpc: got %h want 30", ir_pc); end
  endtask

  task automatic test_redirect_req();
    lat      = 1;
    reset_dut();
    ir_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    checks += 2;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rreq_drain_req: got %b want 0", bus.imem_req); end
    if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL rreq_drain_valid: got %b want 0", ir_valid); end
    tick();
    checks += 3;
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rreq_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 8'h20) begin errors++; $display("[TB] FAIL rreq_addr: got %h want 20", bus.imem_addr); end
    if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL rreq_valid: got %b want 0", ir_valid); end
  endtask

  task automatic test_redirect_last_wins();
    lat      = 3;
    reset_dut();
    ir_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 8'h50;
    tick();
    redirect_pc = 8'h60;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    checks += 2;
    if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rlast_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 8'h60) begin errors++; $display("[TB] FAIL rlast_addr: got %h want 60", bus.imem_addr); end
  endtask

  task automatic test_wrap();
    lat = 1;
    reset_dut();
    checks += 2;
    if (bus2.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_req0: got %b want 1", bus2.imem_req); end
    if (bus2.imem_addr !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_addr0: got %h want ff", bus2.imem_addr); end
    tick();
    tick();
    checks += 3;
    if (ir_valid2 !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid: got %b want 1", ir_valid2); end
    if (ir_pc2 !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_irpc: got %h want ff", ir_pc2); end
    if (ir2 !== 16'hC0FF) begin errors++; $display("[TB] FAIL wrap_ir: got %h want c0ff", ir2); end
    tick();
    checks += 2;
    if (bus2.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_req1: got %b want 1", bus2.imem_req); end
    if (bus2.imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL wrap_addr1: got %h want 00", bus2.imem_addr); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    lat = 1;
    reset_dut();
    checks += 2;
    if (fetch_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL perf_rst_fetch: got %h want 0000", fetch_cnt); end
    if (flush_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL perf_rst_flush: got %h want 0000", flush_cnt); end
    ir_ready = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    redirect    = 1'b1;
    redirect_pc = 8'h08;
    tick();
    tick();
    redirect = 1'b0;
    tick();
    checks += 2;
    if (fetch_cnt !== 16'd3) begin errors++; $display("[TB] FAIL perf_fetch: got %0d want 3", fetch_cnt); end
    if (flush_cnt !== 16'd2) begin errors++; $display("[TB] FAIL perf_flush: got %0d want 2", flush_cnt); end
    redirect = 1'b1;
    for (int c = 0; c < 65540; c++) tick();
    redirect = 1'b0;
    tick();
    checks++;
    if (flush_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL perf_sat: got %h want ffff", flush_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(i)};
    test_reset();
    test_fetch_seq();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_wait();
    mem[0] = 16'h0020;
    test_redirect_same_cycle();
    test_redirect_req();
    test_redirect_last_wins();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of INSTRUCTION_DECODER.
- Owns the program counter (PC) and issues single-outstanding reads to instruction memory.
- Captures each returned 16-bit word in the instruction register (IR) and presents it to the decoder with a valid/ready handshake.
- Accepts PC redirects (branch/jump resolved downstream via PS/BS) and discards wrong-path fetches.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width
- INSTR_W, 16, instruction width (matches decoder instr input)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request; combinational, high only in S_REQ
- imem_addr  out  ADDR_W  read address; equals pc
- imem_rdata  in  INSTR_W  read data, valid when imem_valid=1
- imem_valid  in  1  one-cycle response pulse; never in the same cycle as its request
- ir  out  INSTR_W  instruction register, drives decoder instr
- ir_pc  out  ADDR_W  address the current ir was fetched from
- ir_valid  out  1  ir holds an undelivered instruction
- ir_ready  in  1  decoder/execute accepts ir this cycle
- redirect  in  1  load a new PC (taken branch/jump)
- redirect_pc  in  ADDR_W  target PC

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, state=S_REQ; imem_req is 0 while rst_n=0.
- FSM states: S_REQ, S_WAIT, S_HOLD, S_DRAIN. Every register updates on the rising edge of clk.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - Next state is S_WAIT.
- S_WAIT: on imem_valid:
  - ir<=imem_rdata, ir_pc<=pc, ir_valid<=1.
  - pc<=pc+1, wrapping from 2^ADDR_W-1 to 0.
  - Next state is S_HOLD.
- S_HOLD:
  - ir_valid=1 and ir is stable.
  - On ir_ready: ir_valid<=0, next state is S_REQ.
- S_DRAIN:
  - Waits for the outstanding response.
  - On imem_valid: the data is dropped (ir unchanged), next state is S_REQ.
- Throughput: at most one instruction per 3 cycles. Latency from request to ir_valid is memory latency + 1 cycle.
- Redirect has the highest priority; it overrides imem_valid and ir_ready in the same cycle. In every state: pc<=redirect_pc, ir_valid<=0.
  - S_REQ (request already issued with the old pc): go to S_DRAIN.
  - S_WAIT: go to S_DRAIN. An imem_valid in the same cycle counts as the drained response, so go to S_REQ instead.
  - S_HOLD: go to S_REQ; ir is not delivered.
  - S_DRAIN: pc updated; stay in S_DRAIN unless imem_valid is high, then go to S_REQ.
- Repeated redirects: the last one wins. There is never more than one outstanding request.
- ir and ir_pc change only on an accepted response; they hold their value while ir_valid=0.
- rst_n asserted mid-transaction: abandons any outstanding request. The memory must not return a response after reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs fetch_cnt[15:0] and flush_cnt[15:0], both reset to 0.
  - fetch_cnt increments on every ir_valid&&ir_ready handshake that is not overridden by redirect.
  - flush_cnt increments on every redirect cycle.
  - Both counters saturate at 16'hFFFF.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cpu_fetch_pkg holds:
  - the fetch_state_t enum (S_REQ, S_WAIT, S_HOLD, S_DRAIN)
  - default widths ADDR_W_DEF=8 and INSTR_W_DEF=16
  - RESET_PC_DEF=0
- Natural sub-module: fetch_perf_counter, a 16-bit saturating counter with async active-low reset and an inc input. It is instantiated twice, only under FETCH_PERF_CNT_EN.

Test Plan:
- Reset release, memory returns 16'h0020 one cycle after the req for addr 0, ir_ready=1 → imem_addr sequence is 0,1,2; ir=16'h0020, ir_pc=0, ir_valid high for exactly 1 cycle.
- ir_ready held 0 for 5 cycles after ir_valid rises → ir stable at its value, imem_req stays 0, pc=1; next request at addr 1 only after ir_ready=1.
- Redirect to 8'h40 while in S_HOLD → ir_valid drops next cycle; next imem_addr=8'h40; the old ir is never accepted.
- Redirect to 8'h10 during S_WAIT, response 16'h1111 arrives 2 cycles later → 16'h1111 discarded, next request at 8'h10, ir_pc=8'h10 on delivery.
- RESET_PC=8'hFF, sequential fetch → addresses FF then 00 (wrap).
- With FETCH_PERF_CNT_EN: 3 deliveries and 2 redirects → fetch_cnt=3, flush_cnt=2; preload near FFFF → holds at FFFF.
